// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream from the host link, packs it into
// 32-bit instruction words and writes them through BRAM port A of the
// instruction memory. The processor is held in reset until a checksum-verified
// image has been completely written.
//
// Frame: LEN_LO, LEN_HI (word count N, little-endian), N*4 data bytes
// (little-endian per word), one checksum byte (XOR of all data bytes).
//
// Ports:
//   clock       system clock, also BRAM clka
//   reset       synchronous active-high reset
//   rx_data     incoming byte
//   rx_valid    rx_data valid this cycle
//   rx_ready    loader accepts a byte (transfer on rx_valid && rx_ready)
//   reload      single-cycle pulse restarting a load
//   mem_en      BRAM ena (always equal to mem_we)
//   mem_we      BRAM wea, one-cycle pulse per word
//   mem_addr    BRAM addra, word address
//   mem_wdata   BRAM dina
//   cpu_hold    1 = keep the processor in reset
//   load_done   image loaded and verified
//   load_error  load rejected
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  reload,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      byte_buf;
    logic [7:0]       csum;

    logic             rx_fire_c;
    logic [CNT_W-1:0] len_c;
    logic             last_word_c;

    assign rx_fire_c   = rx_valid && rx_ready;
    // Full word count as it stands once the high length byte arrives
    assign len_c       = {rx_data, n_words[7:0]};
    assign last_word_c = (word_idx == (n_words - CNT_W'(1)));

    // Loader FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= LEN_LO;
            rx_ready   <= 1'b1;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            byte_buf   <= '0;
            csum       <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            if (reload) begin
                // reload wins over a coincident byte, which is dropped
                state      <= LEN_LO;
                rx_ready   <= 1'b1;
                cpu_hold   <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
                n_words    <= '0;
                word_idx   <= '0;
                byte_idx   <= '0;
                byte_buf   <= '0;
                csum       <= '0;
            end else if (rx_fire_c) begin
                case (state)
                    LEN_LO: begin
                        n_words[7:0] <= rx_data;
                        state        <= LEN_HI;
                    end
                    LEN_HI: begin
                        n_words[15:8] <= rx_data;
                        word_idx      <= '0;
                        byte_idx      <= '0;
                        csum          <= '0;
                        if (32'(len_c) > DEPTH) begin
                            state      <= ERROR;
                            rx_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else if (len_c == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: byte_buf[7:0]   <= rx_data;
                            2'd1: byte_buf[15:8]  <= rx_data;
                            2'd2: byte_buf[23:16] <= rx_data;
                            default: begin
                                // Fourth byte completes the word: issue the write
                                mem_wdata <= {rx_data, byte_buf};
                                mem_addr  <= ADDR_WIDTH'(word_idx);
                                mem_we    <= 1'b1;
                                mem_en    <= 1'b1;
                                word_idx  <= word_idx + CNT_W'(1);
                                if (last_word_c) begin
                                    state <= CSUM;
                                end
                            end
                        endcase
                    end
                    CSUM: begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE / ERROR: rx_ready is low, nothing to accept
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of complete frames, randomized
// frames with random rx_valid gaps checked against a frame-level reference
// model, and hand sequences for reload / reset in the middle of a load.
module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Observed writes
    logic [31:0] wl_addr[$];
    logic [31:0] wl_data[$];
    // Reference model results
    logic [31:0] ex_addr[$];
    logic [31:0] ex_data[$];
    int          ex_outcome;   // 0 = still loading, 1 = done, 2 = error
    logic [7:0]  tx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Record every write strobe and keep ena tied to wea
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wl_addr.push_back(32'(mem_addr));
            wl_data.push_back(mem_wdata);
        end
        if (mem_we === 1'b1 || mem_en === 1'b1)
            chk("mem_en_eq_we", 32'(mem_en), 32'(mem_we));
    end

    // Frame-level reference: parse length, pack words, verify checksum
    task automatic model(input logic [7:0] bs[$]);
        int n;
        logic [7:0] x;
        ex_addr.delete();
        ex_data.delete();
        ex_outcome = 0;
        if (bs.size() < 2) return;
        n = int'(bs[0]) + 256 * int'(bs[1]);
        if (n > 1024) begin
            ex_outcome = 2;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            if (4 * w + 5 < bs.size()) begin
                ex_addr.push_back(32'(w));
                ex_data.push_back({bs[4*w+5], bs[4*w+4], bs[4*w+3], bs[4*w+2]});
            end
        end
        for (int i = 2; i < 4 * n + 2 && i < bs.size(); i++) x = x ^ bs[i];
        if (bs.size() > 4 * n + 2) ex_outcome = (bs[4*n+2] == x) ? 1 : 2;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        if (gap > 0) idle(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        chk("rx_ready_on_send", 32'(rx_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
        chk({tag, "_mem_en"},     32'(mem_en),     32'd0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
        chk({tag, "_load_done"},  32'(load_done),  32'd0);
        chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    task automatic chk_against_model(input string tag);
        chk({tag, "_nwrites"}, 32'(wl_addr.size()), 32'(ex_addr.size()));
        for (int i = 0; i < ex_addr.size() && i < wl_addr.size(); i++) begin
            chk({tag, "_waddr"}, wl_addr[i], ex_addr[i]);
            chk({tag, "_wdata"}, wl_data[i], ex_data[i]);
        end
        chk({tag, "_done"},  32'(load_done),  32'(ex_outcome == 1));
        chk({tag, "_error"}, 32'(load_error), 32'(ex_outcome == 2));
        chk({tag, "_hold"},  32'(cpu_hold),   32'(ex_outcome != 1));
        chk({tag, "_ready"}, 32'(rx_ready),   32'(ex_outcome == 0));
    endtask

    typedef struct {
        string        name;
        logic [127:0] pk;      // frame bytes, first byte in the top octet
        int           len;
        int           nwr;
        logic [31:0]  last_word;
        bit           done;
        bit           err;
    } vec_t;

    vec_t vt[6];

    task automatic load_tx(input logic [127:0] pk, input int len);
        tx.delete();
        for (int i = 0; i < len; i++) tx.push_back(pk[127-8*i -: 8]);
    endtask

    initial begin
        vt[0] = '{"good3",   128'h0300_1300_1000_9300_2000_3301_2100_A300, 15, 3, 32'h0021_0133, 1'b1, 1'b0};
        vt[1] = '{"zero",    128'h0,                                        3,  0, 32'h0,         1'b1, 1'b0};
        vt[2] = '{"badsum",  128'h0300_1300_1000_9300_2000_3301_2100_5C00, 15, 3, 32'h0021_0133, 1'b0, 1'b1};
        vt[3] = '{"over",    128'h0104_0000_0000_0000_0000_0000_0000_0000, 2,  0, 32'h0,         1'b0, 1'b1};
        vt[4] = '{"n1024",   128'h0004_1300_1000_9300_0000_0000_0000_0000, 7,  1, 32'h0010_0013, 1'b0, 1'b0};
        vt[5] = '{"oneword", 128'h0100_EFBE_ADDE_2200_0000_0000_0000_0000, 7,  1, 32'hDEAD_BEEF, 1'b1, 1'b0};

        do_reset();
        chk_reset_values("por");

        // Table of whole frames, back-to-back bytes
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load_tx(vt[v].pk, vt[v].len);
            model(tx);
            foreach (tx[i]) begin
                send_byte(tx[i], 0);
                if (i == tx.size() - 1 && vt[v].done) begin
                    chk({vt[v].name, "_done_next"}, 32'(load_done), 32'd1);
                    chk({vt[v].name, "_hold_next"}, 32'(cpu_hold),  32'd0);
                end
            end
            idle(3);
            chk({vt[v].name, "_nwr"},   32'(wl_addr.size()), 32'(vt[v].nwr));
            if (vt[v].nwr > 0 && wl_data.size() > 0)
                chk({vt[v].name, "_lastw"}, wl_data[wl_data.size()-1], vt[v].last_word);
            chk({vt[v].name, "_done"},  32'(load_done),  32'(vt[v].done));
            chk({vt[v].name, "_err"},   32'(load_error), 32'(vt[v].err));
            chk({vt[v].name, "_hold"},  32'(cpu_hold),   32'(!vt[v].done));
            chk({vt[v].name, "_ready"}, 32'(rx_ready),   32'(!vt[v].done && !vt[v].err));
            chk_against_model(vt[v].name);
        end

        // Randomized frames with random rx_valid gaps
        for (int it = 0; it < 20; it++) begin
            do_reset();
            if (it == 0) begin
                load_tx(vt[0].pk, vt[0].len);
            end else begin
                int n;
                logic [7:0] x;
                logic [7:0] b;
                n = $urandom_range(1, 6);
                tx.delete();
                tx.push_back(8'(n));
                tx.push_back(8'h00);
                x = 8'h00;
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    tx.push_back(b);
                    x = x ^ b;
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                tx.push_back(x);
            end
            model(tx);
            foreach (tx[i]) send_byte(tx[i], $urandom_range(0, 5));
            idle(2);
            chk_against_model("rand");
        end

        // reload during word 1 with a byte on the bus; that byte is dropped
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        chk("w0_we",   32'(mem_we),   32'd1);
        chk("w0_addr", 32'(mem_addr), 32'd0);
        chk("w0_data", mem_wdata,     32'h0010_0013);
        send_byte(8'h93, 0);
        chk("w0_pulse_1cyc", 32'(mem_we), 32'd0);
        send_byte(8'h00, 0);
        rx_data  = 8'h20;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(posedge clock);
        #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        chk("reload_ready", 32'(rx_ready), 32'd1);
        chk("reload_hold",  32'(cpu_hold), 32'd1);
        wl_addr.delete();
        wl_data.delete();
        load_tx(vt[5].pk, vt[5].len);
        foreach (tx[i]) send_byte(tx[i], 0);
        idle(2);
        chk("reload_nwr", 32'(wl_addr.size()), 32'd1);
        if (wl_addr.size() > 0) begin
            chk("reload_addr", wl_addr[0], 32'd0);
            chk("reload_data", wl_data[0], 32'hDEAD_BEEF);
        end
        chk("reload_done", 32'(load_done), 32'd1);

        // reload out of DONE
        reload = 1'b1;
        @(posedge clock);
        #1;
        reload = 1'b0;
        chk("rl_done_done",  32'(load_done), 32'd0);
        chk("rl_done_hold",  32'(cpu_hold),  32'd1);
        chk("rl_done_ready", 32'(rx_ready),  32'd1);

        // reset mid-DATA, coinciding with a word's fourth byte
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        chk_reset_values("midrst");
        idle(2);
        chk("midrst_nwr", 32'(wl_addr.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
